// File: rtl/optical_frame_tx.sv
// optical_frame_tx: framed serializer driving the optical LED.
// Frame = alternating preamble, start, data LSB-first, optional even parity, stop.
// bit_clk is only edge-detected on the system clock; every bit starts on a tick.
module optical_frame_tx #(
  parameter int   DATA_W        = 8,
  parameter int   PREAMBLE_BITS = 8,
  parameter int   PARITY_EN     = 1,
  parameter logic IDLE_LEVEL    = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bit_clk,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              led_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int MAXB = (PREAMBLE_BITS > DATA_W) ? PREAMBLE_BITS : DATA_W;
  localparam int CW   = $clog2(MAXB + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_PRE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t            state, state_nx;
  logic              bit_clk_d;
  logic              tick;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic              par_q, par_nx;
  logic              led_nx, fd_nx;

  assign tick       = bit_clk & ~bit_clk_d;
  assign data_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);

  // State, datapath and registered outputs; reset aborts any frame in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      bit_clk_d  <= 1'b0;
      cnt        <= '0;
      shreg      <= '0;
      par_q      <= 1'b0;
      led_out    <= IDLE_LEVEL;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_clk_d  <= bit_clk;
      cnt        <= cnt_nx;
      shreg      <= shreg_nx;
      par_q      <= par_nx;
      led_out    <= led_nx;
      frame_done <= fd_nx;
    end
  end

  // Next state / next outputs; outside the accept cycle nothing moves without a tick.
  // Data is shifted right so the next bit to send always sits in shreg[0].
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shreg_nx = shreg;
    par_nx   = par_q;
    led_nx   = led_out;
    fd_nx    = 1'b0;
    case (state)
      S_IDLE: begin
        // a tick landing on the accept cycle is deliberately dropped
        if (data_valid) begin
          shreg_nx = data_in;
          par_nx   = ^data_in;
          state_nx = S_ARMED;
        end
      end
      S_ARMED: if (tick) begin
        state_nx = S_PRE;
        led_nx   = 1'b1;
        cnt_nx   = CW'(1);
      end
      S_PRE: if (tick) begin
        if (cnt < CW'(PREAMBLE_BITS)) begin
          led_nx = ~led_out;
          cnt_nx = cnt + CW'(1);
        end else begin
          state_nx = S_START;
          led_nx   = ~IDLE_LEVEL;
        end
      end
      S_START: if (tick) begin
        state_nx = S_DATA;
        led_nx   = shreg[0];
        shreg_nx = shreg >> 1;
        cnt_nx   = CW'(1);
      end
      S_DATA: if (tick) begin
        if (cnt < CW'(DATA_W)) begin
          led_nx   = shreg[0];
          shreg_nx = shreg >> 1;
          cnt_nx   = cnt + CW'(1);
        end else if (PARITY_EN != 0) begin
          state_nx = S_PAR;
          led_nx   = par_q;
        end else begin
          state_nx = S_STOP;
          led_nx   = IDLE_LEVEL;
        end
      end
      S_PAR: if (tick) begin
        state_nx = S_STOP;
        led_nx   = IDLE_LEVEL;
      end
      S_STOP: if (tick) begin
        state_nx = S_IDLE;
        led_nx   = IDLE_LEVEL;
        fd_nx    = 1'b1;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = S_IDLE;
        led_nx   = IDLE_LEVEL;
      end
    endcase
  end

endmodule
